mac_parallel_seq_ctrl: RTL and testbench
========================================

# mac_parallel_seq_ctrl

Job sequencer for the 16-lane parallel MAC datapath (unregistered-operand variant: `psum_1` stage on `mul_en`, `psum_total_reg`/`accum_out` stages on `acc_en`). It accepts a job descriptor (vector count, chain flag) and streams operand vectors into the MAC with a valid/ready handshake. It drives `mul_en`/`acc_en`/`load_accum` so that stalls, pipeline drain and accumulator seeding are exact, then holds the MAC result until the consumer accepts it.

## Interface

Parameters:
- `CNT_W`, 8: width of the job vector count and vector index.
- `DRAIN_CYC`, 2: number of `acc_en`-only cycles after the last vector. This is fixed by the MAC pipeline; other values are unsupported.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high. Shared with the MAC.
- `job_valid`  in  1  job descriptor valid.
- `job_ready`  out  1  controller can accept a job.
- `job_len`  in  CNT_W  number of vectors N in the job (0 allowed).
- `job_chain`  in  1  when 1, continue from the existing `accum_out`; when 0, seed from `accum_prev`.
- `vec_valid`  in  1  operand vector present on the MAC `act_in`/`w_in` inputs.
- `vec_ready`  out  1  controller consumes the vector this cycle.
- `vec_idx`  out  CNT_W  index of the vector currently requested (0..N-1).
- `mul_en`, `acc_en`, `load_accum`  out  1 each  MAC controls.
- `out_valid`  out  1  MAC `result` holds the job result.
- `out_ready`  in  1  consumer accepts the result.
- `busy`  out  1  state ≠ IDLE.

## Operation

- States: IDLE, RUN, DRAIN, DONE. Reset forces IDLE from any state.
- IDLE:
  - `job_ready`=1.
  - On `job_valid`: latch `job_len` and `job_chain`, clear `vec_idx` and `adv_cnt`.
  - If N>0, go to RUN; if N=0, go to DONE without touching the MAC.
- RUN:
  - `vec_ready`=1.
  - Advance = `vec_valid`.
  - `mul_en`=`acc_en`=advance. These are combinational from `vec_valid`, so the whole MAC pipeline freezes on bubbles.
  - `vec_idx` increments per accepted vector.
  - After the handshake with `vec_idx`=N-1, go to DRAIN.
- DRAIN:
  - Runs for exactly DRAIN_CYC cycles. `mul_en`=0, `acc_en`=1, `vec_ready`=0.
  - Then go to DONE.
- DONE:
  - `out_valid`=1. All MAC enables are 0, so `result` is stable.
  - On `out_ready`, go to IDLE.
- `adv_cnt`:
  - Counts advances (cycles with `acc_en`=1) in the job. It saturates at 3.
  - The first two advances of a job add stale/garbage pipeline contents into `accum_out`.
  - `load_accum`=1 exactly on the advance where `adv_cnt`==2 and latched `job_chain`==0. This overwrites the garbage with `accum_prev` + psum(v0).
  - When `job_chain`==1, `load_accum` is never asserted; the first two advances then add only already-consumed psums, which are zero after the previous job's drain. The design relies on the previous job's final drain cycle to make this true.
- `load_accum`=0 whenever `acc_en`=0.
- `busy`=1 in RUN, DRAIN and DONE.
- A job is N+2 advances total (N vector advances plus 2 drain advances). Final value: `accum_out` = seed + Σ psum(v0..vN-1). The seed is `accum_prev` when `job_chain`=0, or the prior `accum_out` when `job_chain`=1.
- Width/overflow behaviour is owned by the MAC. The controller performs no arithmetic.

## Timing

- Reset values: state=IDLE, `vec_idx`=0, `adv_cnt`=0.
- While `reset`=1, all outputs are 0, including `job_ready`. In the first cycle after reset deasserts, `job_ready`=1.
- Job handshake in cycle T: RUN begins at T+1.
- With `vec_valid` held high, vectors are consumed in cycles T+1..T+N, DRAIN occupies T+N+1..T+N+2, and `out_valid` rises in T+N+3.
- Each cycle of `vec_valid`=0 in RUN adds one cycle of latency and produces no enable pulses.
- `out_valid` and `result` stay stable until `out_ready`. IDLE (`job_ready`=1) is entered the cycle after the handshake; no job overlap.
- N=0: `out_valid` is asserted at T+1, and `result` is the unchanged `accum_out`.
- Reset mid-job: the job is aborted. There is no partial result and no `out_valid`.

## Test plan

- **Back-to-back stream.** N=4, `job_chain`=0, `accum_prev`=0, all lanes act=w=64, `vec_valid` held high.
  - `mul_en` high T+1..T+4.
  - `acc_en` high T+1..T+6.
  - `load_accum` only at T+3.
  - `out_valid` at T+7, `result`=0x0400 (`accum_out`=0x040000).
- **Input bubbles.** Same job with `vec_valid` pattern 1,0,0,1,0,1,1.
  - `acc_en`/`mul_en` low exactly in bubble cycles.
  - `result`=0x0400; `out_valid` 3 cycles later than back-to-back.
- **Single vector with seed.** N=1, `accum_prev`=0x00FF00, act=w=16.
  - `load_accum` in the second DRAIN cycle.
  - `accum_out`=0x00FF00+0x1000=0x010F00, `result`=0x010F.
- **Chained jobs.** Job A: N=2, `job_chain`=0, act=w=64. Job B: N=2, `job_chain`=1, act=w=64.
  - A `result`=0x0200.
  - B `result`=0x0400.
  - No `load_accum` during B.
- **Output backpressure and zero-length job.**
  - Hold `out_ready`=0 for 5 cycles: `out_valid` and `result` stay constant, `job_ready`=0, and a pending `job_valid` is not taken.
  - A subsequent `job_len`=0 job gives `out_valid` one cycle after accept, with no enable pulses.
- **Reset mid-RUN.** Assert `reset` after 2 of 4 vectors.
  - All outputs 0 during reset; `job_ready`=1 the next cycle.
  - A fresh N=4, act=w=64 job returns `result`=0x0400.

Source files
------------

// File: rtl/mac_parallel_seq_ctrl.sv
// mac_parallel_seq_ctrl
//
// Job sequencer for the 16-lane parallel MAC (unregistered-operand variant).
// Accepts a job descriptor, streams operand vectors into the MAC with a
// valid/ready handshake, drives mul_en/acc_en/load_accum so that stalls, the
// pipeline drain and accumulator seeding are exact, and then holds the result
// until the consumer takes it.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset (shared with MAC)
//   job_valid/ready   job descriptor handshake; job_len = vector count N,
//                     job_chain = 1 continues from accum_out, 0 seeds from
//                     accum_prev
//   vec_valid/ready   operand vector handshake; vec_idx = requested vector
//   mul_en, acc_en,   MAC pipeline controls
//   load_accum
//   out_valid/ready   result handshake
//   busy              controller is not idle
module mac_parallel_seq_ctrl #(
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned DRAIN_CYC = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             job_valid,
    output logic             job_ready,
    input  logic [CNT_W-1:0] job_len,
    input  logic             job_chain,
    input  logic             vec_valid,
    output logic             vec_ready,
    output logic [CNT_W-1:0] vec_idx,
    output logic             mul_en,
    output logic             acc_en,
    output logic             load_accum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    localparam int unsigned DrainW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    len_q, len_d;
    logic                chain_q, chain_d;
    logic [CNT_W-1:0]    idx_q, idx_d;
    logic [1:0]          adv_q, adv_d;
    logic [DrainW-1:0]   drain_q, drain_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            len_q   <= '0;
            chain_q <= 1'b0;
            idx_q   <= '0;
            adv_q   <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            chain_q <= chain_d;
            idx_q   <= idx_d;
            adv_q   <= adv_d;
            drain_q <= drain_d;
        end
    end

    logic job_ready_c, vec_ready_c, mul_en_c, acc_en_c, out_valid_c;

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        chain_d     = chain_q;
        idx_d       = idx_q;
        adv_d       = adv_q;
        drain_d     = drain_q;
        job_ready_c = 1'b0;
        vec_ready_c = 1'b0;
        mul_en_c    = 1'b0;
        acc_en_c    = 1'b0;
        out_valid_c = 1'b0;

        unique case (state_q)
            StIdle: begin
                job_ready_c = 1'b1;
                if (job_valid) begin
                    len_d   = job_len;
                    chain_d = job_chain;
                    idx_d   = '0;
                    adv_d   = '0;
                    // Zero-length job leaves the MAC untouched
                    state_d = (job_len == '0) ? StDone : StRun;
                end
            end
            StRun: begin
                vec_ready_c = 1'b1;
                // Enables follow vec_valid directly so a bubble freezes the pipe
                mul_en_c    = vec_valid;
                acc_en_c    = vec_valid;
                if (vec_valid) begin
                    idx_d = idx_q + CNT_W'(1);
                    if (idx_q == len_q - CNT_W'(1)) begin
                        drain_d = '0;
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                acc_en_c = 1'b1;
                drain_d  = drain_q + DrainW'(1);
                if (drain_q == DrainW'(DRAIN_CYC - 1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                out_valid_c = 1'b1;
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Advance counter saturates at 3; only values 0..2 matter for seeding
        if (acc_en_c && adv_q != 2'd3) begin
            adv_d = adv_q + 2'd1;
        end
    end

    // Outputs forced low while reset is held, independent of register state
    always_comb begin
        job_ready  = 1'b0;
        vec_ready  = 1'b0;
        vec_idx    = '0;
        mul_en     = 1'b0;
        acc_en     = 1'b0;
        load_accum = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        if (!reset) begin
            job_ready  = job_ready_c;
            vec_ready  = vec_ready_c;
            vec_idx    = idx_q;
            mul_en     = mul_en_c;
            acc_en     = acc_en_c;
            // Third advance carries psum(v0) into accum; overwrite the garbage
            // from the first two advances with accum_prev + psum(v0)
            load_accum = acc_en_c && (adv_q == 2'd2) && !chain_q;
            out_valid  = out_valid_c;
            busy       = (state_q != StIdle);
        end
    end

endmodule

// File: tb/tb_mac_parallel_seq_ctrl.sv
module tb_mac_parallel_seq_ctrl;

    logic       clk;
    logic       reset;
    logic       job_valid;
    logic       job_ready;
    logic [7:0] job_len;
    logic       job_chain;
    logic       vec_valid;
    logic       vec_ready;
    logic [7:0] vec_idx;
    logic       mul_en;
    logic       acc_en;
    logic       load_accum;
    logic       out_valid;
    logic       out_ready;
    logic       busy;

    mac_parallel_seq_ctrl #(
        .CNT_W     (8),
        .DRAIN_CYC (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .job_valid  (job_valid),
        .job_ready  (job_ready),
        .job_len    (job_len),
        .job_chain  (job_chain),
        .vec_valid  (vec_valid),
        .vec_ready  (vec_ready),
        .vec_idx    (vec_idx),
        .mul_en     (mul_en),
        .acc_en     (acc_en),
        .load_accum (load_accum),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected output word: {job_ready, vec_ready, vec_idx[7:0], mul_en, acc_en,
    // load_accum, out_valid, busy}
    typedef struct {
        logic        rst;
        logic        jv;
        logic [7:0]  jl;
        logic        jc;
        logic        vv;
        logic        ordy;
        logic [14:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   n_applied = 0;
    int   n_fail    = 0;

    function automatic logic [14:0] ex(logic jr, logic vr, logic [7:0] idx, logic mul,
                                       logic acc, logic ld, logic ov, logic bz);
        return {jr, vr, idx, mul, acc, ld, ov, bz};
    endfunction

    function automatic logic [14:0] outs();
        return {job_ready, vec_ready, vec_idx, mul_en, acc_en, load_accum, out_valid, busy};
    endfunction

    task automatic add(logic rst, logic jv, logic [7:0] jl, logic jc, logic vv, logic ordy,
                       logic [14:0] e);
        vec_t v;
        v.rst = rst; v.jv = jv; v.jl = jl; v.jc = jc; v.vv = vv; v.ordy = ordy; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic drive(logic rst, logic jv, logic [7:0] jl, logic jc, logic vv, logic ordy);
        reset = rst; job_valid = jv; job_len = jl; job_chain = jc;
        vec_valid = vv; out_ready = ordy;
    endtask

    task automatic chk(string nm, logic [14:0] e);
        logic [14:0] a;
        a = outs();
        n_applied++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got {jr,vr,idx,mul,acc,ld,ov,busy}=%b_%b_%h_%b%b%b_%b_%b want %b_%b_%h_%b%b%b_%b_%b",
                     nm, a[14], a[13], a[12:5], a[4], a[3], a[2], a[1], a[0],
                     e[14], e[13], e[12:5], e[4], e[3], e[2], e[1], e[0]);
        end
    endtask

    task automatic chk_int(string nm, int a, int e);
        n_applied++;
        if (a != e) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d", nm, a, e);
        end
    endtask

    initial begin
        int mul_cnt, acc_cnt, ld_cnt, ld_cyc, ov_cyc;

        drive(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);

        // rst jv jl jc vv ordy | jr vr idx mul acc ld ov busy
        // Reset: outputs all zero even with live inputs
        add(1, 0, 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0, 0));
        add(1, 1, 4, 0, 1, 1, ex(0, 0, 0, 0, 0, 0, 0, 0));
        add(0, 0, 0, 0, 0, 0, ex(1, 0, 0, 0, 0, 0, 0, 0));
        // Back-to-back N=4, chain=0: load at T+3, DONE at T+7
        add(0, 1, 4, 0, 0, 0, ex(1, 0, 0, 0, 0, 0, 0, 0));
        add(0, 0, 0, 0, 1, 0, ex(0, 1, 0, 1, 1, 0, 0, 1));
        add(0, 0, 0, 0, 1, 0, ex(0, 1, 1, 1, 1, 0, 0, 1));
        add(0, 0, 0, 0, 1, 0, ex(0, 1, 2, 1, 1, 1, 0, 1));
        add(0, 0, 0, 0, 1, 0, ex(0, 1, 3, 1, 1, 0, 0, 1));
        add(0, 0, 0, 0, 1, 0, ex(0, 0, 4, 0, 1, 0, 0, 1));
        add(0, 0, 0, 0, 1, 0, ex(0, 0, 4, 0, 1, 0, 0, 1));
        add(0, 0, 0, 0, 0, 1, ex(0, 0, 4, 0, 0, 0, 1, 1));
        add(0, 0, 0, 0, 0, 0, ex(1, 0, 4, 0, 0, 0, 0, 0));
        // Bubbles 1,0,0,1,0,1,1: enables low in bubble cycles, DONE at T+10
        add(0, 1, 4, 0, 0, 0, ex(1, 0, 4, 0, 0, 0, 0, 0));
        add(0, 0, 0, 0, 1, 0, ex(0, 1, 0, 1, 1, 0, 0, 1));
        add(0, 0, 0, 0, 0, 0, ex(0, 1, 1, 0, 0, 0, 0, 1));
        add(0, 0, 0, 0, 0, 0, ex(0, 1, 1, 0, 0, 0, 0, 1));
        add(0, 0, 0, 0, 1, 0, ex(0, 1, 1, 1, 1, 0, 0, 1));
        add(0, 0, 0, 0, 0, 0, ex(0, 1, 2, 0, 0, 0, 0, 1));
        add(0, 0, 0, 0, 1, 0, ex(0, 1, 2, 1, 1, 1, 0, 1));
        add(0, 0, 0, 0, 1, 0, ex(0, 1, 3, 1, 1, 0, 0, 1));
        add(0, 0, 0, 0, 0, 0, ex(0, 0, 4, 0, 1, 0, 0, 1));
        add(0, 0, 0, 0, 0, 0, ex(0, 0, 4, 0, 1, 0, 0, 1));
        add(0, 0, 0, 0, 0, 1, ex(0, 0, 4, 0, 0, 0, 1, 1));
        // Single vector with seed: load in second drain cycle
        add(0, 1, 1, 0, 0, 0, ex(1, 0, 4, 0, 0, 0, 0, 0));
        add(0, 0, 0, 0, 1, 0, ex(0, 1, 0, 1, 1, 0, 0, 1));
        add(0, 0, 0, 0, 1, 0, ex(0, 0, 1, 0, 1, 0, 0, 1));
        add(0, 0, 0, 0, 1, 0, ex(0, 0, 1, 0, 1, 1, 0, 1));
        add(0, 0, 0, 0, 0, 1, ex(0, 0, 1, 0, 0, 0, 1, 1));
        // Chained: job A N=2 chain=0
        add(0, 1, 2, 0, 0, 0, ex(1, 0, 1, 0, 0, 0, 0, 0));
        add(0, 0, 0, 0, 1, 0, ex(0, 1, 0, 1, 1, 0, 0, 1));
        add(0, 0, 0, 0, 1, 0, ex(0, 1, 1, 1, 1, 0, 0, 1));
        add(0, 0, 0, 0, 0, 0, ex(0, 0, 2, 0, 1, 1, 0, 1));
        add(0, 0, 0, 0, 0, 0, ex(0, 0, 2, 0, 1, 0, 0, 1));
        add(0, 0, 0, 0, 0, 1, ex(0, 0, 2, 0, 0, 0, 1, 1));
        // Job B N=2 chain=1: no load_accum anywhere
        add(0, 1, 2, 1, 0, 0, ex(1, 0, 2, 0, 0, 0, 0, 0));
        add(0, 0, 0, 0, 1, 0, ex(0, 1, 0, 1, 1, 0, 0, 1));
        add(0, 0, 0, 0, 1, 0, ex(0, 1, 1, 1, 1, 0, 0, 1));
        add(0, 0, 0, 0, 0, 0, ex(0, 0, 2, 0, 1, 0, 0, 1));
        add(0, 0, 0, 0, 0, 0, ex(0, 0, 2, 0, 1, 0, 0, 1));
        // Backpressure 5 cycles with a pending zero-length job not taken
        for (int i = 0; i < 5; i++) add(0, 1, 0, 0, 1, 0, ex(0, 0, 2, 0, 0, 0, 1, 1));
        add(0, 1, 0, 0, 1, 1, ex(0, 0, 2, 0, 0, 0, 1, 1));
        // Zero-length job: DONE next cycle, no enables even with vec_valid high
        add(0, 1, 0, 0, 1, 0, ex(1, 0, 2, 0, 0, 0, 0, 0));
        add(0, 0, 0, 0, 1, 1, ex(0, 0, 0, 0, 0, 0, 1, 1));
        add(0, 0, 0, 0, 0, 0, ex(1, 0, 0, 0, 0, 0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].jv, vecs[i].jl, vecs[i].jc, vecs[i].vv, vecs[i].ordy);
            #1;
            chk($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Reset in the middle of RUN after two vectors
        @(negedge clk); drive(0, 1, 4, 0, 0, 0); #1;
        chk("rst_seq_accept", ex(1, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk); drive(0, 0, 0, 0, 1, 0); #1;
        chk("rst_seq_v0", ex(0, 1, 0, 1, 1, 0, 0, 1));
        @(negedge clk); drive(0, 0, 0, 0, 1, 0); #1;
        chk("rst_seq_v1", ex(0, 1, 1, 1, 1, 0, 0, 1));
        @(negedge clk); drive(1, 1, 4, 0, 1, 1); #1;
        chk("rst_seq_during", ex(0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk); drive(0, 0, 0, 0, 0, 0); #1;
        chk("rst_seq_after", ex(1, 0, 0, 0, 0, 0, 0, 0));

        // Fresh N=4 job after the abort, counted with a bounded wait
        @(negedge clk); drive(0, 1, 4, 0, 0, 0); #1;
        chk("fresh_accept", ex(1, 0, 0, 0, 0, 0, 0, 0));
        mul_cnt = 0; acc_cnt = 0; ld_cnt = 0; ld_cyc = -1; ov_cyc = -1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk); drive(0, 0, 0, 0, 1, 0); #1;
            if (out_valid) begin
                ov_cyc = c;
                break;
            end
            mul_cnt += int'(mul_en);
            acc_cnt += int'(acc_en);
            if (load_accum) begin
                ld_cnt++;
                ld_cyc = c;
            end
        end
        chk_int("fresh_out_valid_cycle", ov_cyc, 7);
        chk_int("fresh_mul_pulses", mul_cnt, 4);
        chk_int("fresh_acc_pulses", acc_cnt, 6);
        chk_int("fresh_load_pulses", ld_cnt, 1);
        chk_int("fresh_load_cycle", ld_cyc, 3);
        @(negedge clk); drive(0, 0, 0, 0, 0, 1); #1;
        chk("fresh_done_hold", ex(0, 0, 4, 0, 0, 0, 1, 1));
        @(negedge clk); drive(0, 0, 0, 0, 0, 0); #1;
        chk("fresh_idle", ex(1, 0, 4, 0, 0, 0, 0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_fail);
        $finish;
    end

endmodule
